// File: rtl/updown_mod_counter_pkg.sv
// Shared definitions for the up/down modulus counter: direction and mode
// encodings plus the next-state function. The function works on a fixed
// 32-bit datapath so any counter width up to 31 bits can use it.
package counter_pkg;

    localparam logic CNT_UP    = 1'b1;
    localparam logic CNT_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int CNT_MAXW = 32;

    // Result of one enabled step: next value, whether a boundary was hit,
    // and whether that boundary step wrapped (as opposed to saturating).
    typedef struct packed {
        logic [CNT_MAXW-1:0] value;
        logic                boundary;
        logic                wrapped;
    } next_t;

    // Next count for an enabled step. Only the top value (modulus-1) and
    // zero are compared, so the result never exceeds modulus-1.
    function automatic next_t next_count(
        input logic [CNT_MAXW-1:0] cur,
        input logic                up_dn,
        input logic                sat,
        input logic [CNT_MAXW-1:0] modulus
    );
        next_t               r;
        logic [CNT_MAXW-1:0] top;
        top        = modulus - 32'd1;
        r.value    = cur;
        r.boundary = 1'b0;
        r.wrapped  = 1'b0;
        if (up_dn == CNT_UP) begin
            if (cur == top) begin
                r.boundary = 1'b1;
                if (sat == MODE_SAT) begin
                    r.value = top;
                end else begin
                    r.value   = '0;
                    r.wrapped = 1'b1;
                end
            end else begin
                r.value = cur + 32'd1;
            end
        end else begin
            if (cur == '0) begin
                r.boundary = 1'b1;
                if (sat == MODE_SAT) begin
                    r.value = '0;
                end else begin
                    r.value   = top;
                    r.wrapped = 1'b1;
                end
            end else begin
                r.value = cur - 32'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of the up/down modulus counter. The master side
// drives the controls and observes the count; the counter is the slave.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             sat;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up_dn, load, load_val, sat, clr_ovf,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  en, up_dn, load, load_val, sat, clr_ovf,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Parametrised up/down counter with programmable modulus, parallel load,
// wrap/saturate boundary mode, one-cycle wrap pulse and sticky overflow.
// tc is combinational so instances chain through tc -> en on one clock.
// WIDTH is limited to 31 bits by the shared next-state function.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input logic                  clk,
    input logic                  rst,
    updown_mod_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0]    MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0]    RST_VAL = WIDTH'(RESET_VAL);
    localparam logic [CNT_MAXW-1:0] MOD_W   = CNT_MAXW'(MODULUS);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             wrap_reg, wrap_next;
    logic             ovf_reg, ovf_next;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_val;
    next_t            step;

    // Enabled-step result for the current count and controls.
    always_comb begin
        step = next_count(CNT_MAXW'(count_reg), bus.up_dn, bus.sat, MOD_W);
    end

    assign step_val = step.value[WIDTH-1:0];

    // Upper bits of the shared datapath are always zero for this width.
    generate
        if (WIDTH < CNT_MAXW) begin : g_unused
            logic unused_hi;
            assign unused_hi = |step.value[CNT_MAXW-1:WIDTH];
        end
    endgenerate

    // Out-of-range load values are clamped so count never leaves 0..MODULUS-1.
    assign load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

    // Priority load > enable > hold; a boundary step beats clr_ovf.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        ovf_next   = ovf_reg & ~bus.clr_ovf;
        if (bus.load) begin
            count_next = load_clamped;
            ovf_next   = 1'b0;
        end else if (bus.en) begin
            count_next = step_val;
            wrap_next  = step.wrapped;
            if (step.boundary) begin
                ovf_next = 1'b1;
            end
        end
    end

    // State registers; reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= RST_VAL;
            wrap_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Terminal count is live in the same cycle as the boundary for cascading.
    assign bus.tc    = bus.en & ~bus.load &
                       (bus.up_dn ? (count_reg == MAX_VAL) : (count_reg == '0));
    assign bus.count = count_reg;
    assign bus.wrap  = wrap_reg;
    assign bus.ovf   = ovf_reg;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=4, MODULUS=10):
// vector table for load/direction/mode behaviour, hand sequences for
// reset, wrap-up counting and a two-digit cascade.
module tb_updown_mod_counter;

    logic clk;
    logic rst;

    updown_mod_counter_if #(.WIDTH(4)) bus ();
    updown_mod_counter_if #(.WIDTH(4)) bl ();
    updown_mod_counter_if #(.WIDTH(4)) bh ();

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_lo (
        .clk (clk),
        .rst (rst),
        .bus (bl)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_hi (
        .clk (clk),
        .rst (rst),
        .bus (bh)
    );

    // Tens digit advances only when the units digit reports terminal count.
    assign bh.en = bl.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       up_dn;
        logic       load;
        logic       sat;
        logic       clr;
        logic [3:0] lv;
        logic [3:0] e_cnt;
        logic       e_tc;
        logic       e_wrap;
        logic       e_ovf;
    } vec_t;

    typedef struct packed {
        logic [3:0] cnt;
        logic       wrap;
        logic       ovf;
    } exp_t;

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
    } casc_t;

    vec_t  vecs[$];
    exp_t  sb_q[$];
    casc_t cq[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic up_dn, input logic load,
                       input logic sat, input logic clr, input logic [3:0] lv,
                       input logic [3:0] e_cnt, input logic e_tc,
                       input logic e_wrap, input logic e_ovf);
        vec_t v;
        v.en = en; v.up_dn = up_dn; v.load = load; v.sat = sat; v.clr = clr;
        v.lv = lv; v.e_cnt = e_cnt; v.e_tc = e_tc; v.e_wrap = e_wrap; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    // One clocked transaction, entered and left at a falling edge.
    task automatic step(input string name, input logic en, input logic up_dn,
                        input logic load, input logic sat, input logic clr,
                        input logic [3:0] lv, input logic [3:0] e_cnt,
                        input logic e_tc, input logic e_wrap, input logic e_ovf);
        exp_t e;
        bus.en = en; bus.up_dn = up_dn; bus.load = load;
        bus.sat = sat; bus.clr_ovf = clr; bus.load_val = lv;
        #1;
        chk({name, " tc"}, 32'(bus.tc), 32'(e_tc));
        sb_q.push_back('{cnt: e_cnt, wrap: e_wrap, ovf: e_ovf});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({name, " count"}, 32'(bus.count), 32'(e.cnt));
        chk({name, " wrap"},  32'(bus.wrap),  32'(e.wrap));
        chk({name, " ovf"},   32'(bus.ovf),   32'(e.ovf));
        $display("[TB] %s: en=%0b up=%0b load=%0b sat=%0b clr=%0b lv=%0d -> count=%0d tc=%0b wrap=%0b ovf=%0b",
                 name, en, up_dn, load, sat, clr, lv, bus.count, e_tc, bus.wrap, bus.ovf);
        @(negedge clk);
    endtask

    initial begin
        casc_t c;

        // Table: en, up_dn, load, sat, clr, load_val | count, tc, wrap, ovf
        // Down from a load of 2 with wrap through zero.
        add(0,1,1,0,0, 2,  2,0,0,0);
        add(1,0,0,0,0, 0,  1,0,0,0);
        add(1,0,0,0,0, 0,  0,0,0,0);
        add(1,0,0,0,0, 0,  9,1,1,1);
        add(1,0,0,0,0, 0,  8,0,0,1);
        // Saturating up from 7, then reverse direction.
        add(0,1,1,1,0, 7,  7,0,0,0);
        add(1,1,0,1,0, 0,  8,0,0,0);
        add(1,1,0,1,0, 0,  9,0,0,0);
        add(1,1,0,1,0, 0,  9,1,0,1);
        add(1,1,0,1,0, 0,  9,1,0,1);
        add(1,0,0,1,0, 0,  8,0,0,1);
        // clr_ovf alone, then clr_ovf against a boundary step.
        add(0,0,0,1,1, 0,  8,0,0,0);
        add(0,0,1,1,0, 0,  0,0,0,0);
        add(1,0,0,1,1, 0,  0,1,0,1);
        add(1,0,0,0,1, 0,  9,1,1,1);
        add(0,0,0,0,0, 0,  9,0,0,1);
        // Load clamping and load-over-enable priority.
        add(0,1,1,0,0, 13, 9,0,0,0);
        add(1,1,1,0,0, 4,  4,0,0,0);
        add(0,1,1,0,0, 10, 9,0,0,0);
        add(0,1,0,0,0, 0,  9,0,0,0);
        add(1,1,0,0,0, 0,  0,1,1,1);

        rst = 1'b0;
        bus.en = 0; bus.up_dn = 1; bus.load = 0; bus.sat = 0; bus.clr_ovf = 0; bus.load_val = '0;
        bl.en = 0; bl.up_dn = 1; bl.load = 0; bl.sat = 0; bl.clr_ovf = 0; bl.load_val = '0;
        bh.up_dn = 1; bh.load = 0; bh.sat = 0; bh.clr_ovf = 0; bh.load_val = '0;

        // Reset state, before and after a clock edge with reset held.
        #3;
        chk("reset count", 32'(bus.count), 32'd0);
        chk("reset wrap",  32'(bus.wrap),  32'd0);
        chk("reset ovf",   32'(bus.ovf),   32'd0);
        @(posedge clk);
        #1;
        chk("reset held count", 32'(bus.count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Count up 0..9 and wrap to 0, then one more step.
        for (int i = 0; i <= 10; i++) begin
            step($sformatf("up%0d", i), 1, 1, 0, 0, 0, 4'd0,
                 4'((i + 1) % 10), (i == 9), (i == 9), (i >= 9));
        end

        for (int k = 0; k < vecs.size(); k++) begin
            step($sformatf("vec%0d", k), vecs[k].en, vecs[k].up_dn, vecs[k].load,
                 vecs[k].sat, vecs[k].clr, vecs[k].lv, vecs[k].e_cnt,
                 vecs[k].e_tc, vecs[k].e_wrap, vecs[k].e_ovf);
        end

        // Asynchronous reset in mid-count with ovf set.
        step("rs_load", 0, 1, 1, 0, 0, 4'd8, 4'd8, 0, 0, 0);
        step("rs_a",    1, 1, 0, 0, 0, 4'd0, 4'd9, 0, 0, 0);
        step("rs_b",    1, 1, 0, 0, 0, 4'd0, 4'd0, 1, 1, 1);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("rs_up%0d", i), 1, 1, 0, 0, 0, 4'd0, 4'(i + 1), 0, 0, 1);
        end
        #2;
        rst = 1'b0;
        #1;
        chk("async rst count", 32'(bus.count), 32'd0);
        chk("async rst wrap",  32'(bus.wrap),  32'd0);
        chk("async rst ovf",   32'(bus.ovf),   32'd0);
        $display("[TB] async reset: count=%0d wrap=%0b ovf=%0b", bus.count, bus.wrap, bus.ovf);
        @(posedge clk);
        #1;
        chk("rst held count", 32'(bus.count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("resume%0d", i), 1, 1, 0, 0, 0, 4'd0, 4'(i + 1), 0, 0, 0);
        end
        bus.en = 0;

        // Two-digit cascade 00..99 and back to 00.
        bl.en = 1;
        for (int i = 0; i < 100; i++) begin
            #1;
            chk($sformatf("casc%0d lo tc", i), 32'(bl.tc), 32'((i % 10) == 9));
            chk($sformatf("casc%0d hi tc", i), 32'(bh.tc), 32'(i == 99));
            cq.push_back('{hi: 4'(((i + 1) % 100) / 10), lo: 4'((i + 1) % 10)});
            @(posedge clk);
            #1;
            c = cq.pop_front();
            chk($sformatf("casc%0d lo", i), 32'(bl.count), 32'(c.lo));
            chk($sformatf("casc%0d hi", i), 32'(bh.count), 32'(c.hi));
            $display("[TB] casc%0d: %0d%0d", i, bh.count, bl.count);
            @(negedge clk);
        end
        bl.en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
